// File: rtl/axi4lite_regbank_nxm.sv
// rtl/axi4lite_regbank_nxm.sv - AXI4-Lite slave register bank with N_WR control and N_RD status words
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN          clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*/AR*/R*             AXI4-Lite slave channels (AWPROT/ARPROT ignored)
//   sw_write32                         flattened control words, word k at [32k+31:32k]
//   sw_read32                          flattened status inputs, same layout
//   sw_wr_pulse / sw_rd_pulse          one-cycle strobes on accepted control writes / status reads
module axi4lite_regbank_nxm #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 11,
  parameter int N_WR = 4,
  parameter int N_RD = 4
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [N_WR*C_S_AXI_DATA_WIDTH-1:0]   sw_write32,
  input  logic [N_RD*C_S_AXI_DATA_WIDTH-1:0]   sw_read32,
  output logic [N_WR-1:0]                      sw_wr_pulse,
  output logic [N_RD-1:0]                      sw_rd_pulse
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] REG_CTL = 2'd0;
  localparam logic [1:0] REG_STS = 2'd1;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t         wstate;
  rstate_t         rstate;
  logic            live;       // holds the ready outputs low until the first edge after reset
  logic [DW-1:0]   regs [N_WR];
  logic            aw_done, w_done;
  logic [IW-1:0]   aw_idx_q;
  logic [DW-1:0]   wdata_q;
  logic [NB-1:0]   wstrb_q;

  logic            aw_hs, w_hs, do_write;
  logic [IW-1:0]   w_idx, r_idx;
  logic [DW-1:0]   w_data, r_word;
  logic [NB-1:0]   w_strb;
  logic [1:0]      w_reg, r_resp;
  logic [N_RD-1:0] r_hit;
  logic            unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // 0 = control, 1 = status, 2 = unmapped
  function automatic logic [1:0] region(input logic [IW-1:0] idx);
    if (32'(idx) < 32'(N_WR)) return REG_CTL;
    if (32'(idx) < 32'(N_WR + N_RD)) return REG_STS;
    return 2'd2;
  endfunction

  for (genvar g = 0; g < N_WR; g++) begin : g_flat
    assign sw_write32[g*DW +: DW] = regs[g];
  end

  assign S_AXI_AWREADY = live && (wstate == W_IDLE) && !aw_done;
  assign S_AXI_WREADY  = live && (wstate == W_IDLE) && !w_done;
  assign S_AXI_ARREADY = live && (rstate == R_IDLE);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

  // Either half may already be captured or be handshaking this cycle; the write
  // commits at the edge where the second half arrives.
  assign w_idx    = aw_done ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_data   = w_done ? wdata_q : S_AXI_WDATA;
  assign w_strb   = w_done ? wstrb_q : S_AXI_WSTRB;
  assign do_write = (wstate == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
  assign w_reg    = region(w_idx);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wstate       <= W_IDLE;
      live         <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      aw_idx_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      sw_wr_pulse  <= '0;
      for (int k = 0; k < N_WR; k++) regs[k] <= '0;
    end else begin
      live        <= 1'b1;
      sw_wr_pulse <= '0;
      case (wstate)
        W_IDLE: begin
          if (do_write) begin
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            wstate       <= W_RESP;
            if (w_reg == REG_CTL) begin
              S_AXI_BRESP <= RESP_OKAY;
              for (int k = 0; k < N_WR; k++) begin
                if (32'(w_idx) == 32'(k)) begin
                  sw_wr_pulse[k] <= 1'b1;
                  for (int b = 0; b < NB; b++)
                    if (w_strb[b]) regs[k][8*b +: 8] <= w_data[8*b +: 8];
                end
              end
            end else if (w_reg == REG_STS) begin
              S_AXI_BRESP <= RESP_SLVERR;
            end else begin
              S_AXI_BRESP <= RESP_DECERR;
            end
          end else begin
            if (aw_hs) begin
              aw_done  <= 1'b1;
              aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
              w_done  <= 1'b1;
              wdata_q <= S_AXI_WDATA;
              wstrb_q <= S_AXI_WSTRB;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            wstate       <= W_IDLE;
          end
        end
      endcase
    end
  end

  assign r_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  always_comb begin
    r_word = '0;
    r_resp = RESP_DECERR;
    r_hit  = '0;
    case (region(r_idx))
      REG_CTL: begin
        r_resp = RESP_OKAY;
        for (int k = 0; k < N_WR; k++)
          if (32'(r_idx) == 32'(k)) r_word = regs[k];
      end
      REG_STS: begin
        r_resp = RESP_OKAY;
        for (int k = 0; k < N_RD; k++) begin
          if (32'(r_idx) == 32'(N_WR + k)) begin
            r_word   = sw_read32[k*DW +: DW];
            r_hit[k] = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rstate       <= R_IDLE;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
      sw_rd_pulse  <= '0;
    end else begin
      sw_rd_pulse <= '0;
      case (rstate)
        R_IDLE: begin
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_RDATA  <= r_word;
            S_AXI_RRESP  <= r_resp;
            S_AXI_RVALID <= 1'b1;
            sw_rd_pulse  <= r_hit;
            rstate       <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            rstate       <= R_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi4lite_regbank_nxm.sv
// tb/tb_axi4lite_regbank_nxm.sv - self-checking bench for axi4lite_regbank_nxm
module tb_axi4lite_regbank_nxm;
  localparam int N_WR = 4;
  localparam int N_RD = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [10:0]  awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [31:0]  wdata = '0, rdata;
  logic [3:0]   wstrb = '0;
  logic [1:0]   bresp, rresp;
  logic [127:0] sw_write32;
  logic [127:0] sw_read32 = '0;
  logic [3:0]   sw_wr_pulse, sw_rd_pulse;

  int errors = 0;
  int checks = 0;
  int wr_pcnt = 0, rd_pcnt = 0;
  logic [3:0] wr_plast = '0, rd_plast = '0;
  logic [31:0] mdl [N_WR];

  always #5 clk = ~clk;

  axi4lite_regbank_nxm #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(11), .N_WR(N_WR), .N_RD(N_RD)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .sw_write32(sw_write32), .sw_read32(sw_read32),
    .sw_wr_pulse(sw_wr_pulse), .sw_rd_pulse(sw_rd_pulse)
  );

  // Each clock cycle a strobe is high adds one, so a one-cycle strobe adds exactly one.
  always @(negedge clk) begin
    if (sw_wr_pulse != 4'b0) begin wr_pcnt++; wr_plast = sw_wr_pulse; end
    if (sw_rd_pulse != 4'b0) begin rd_pcnt++; rd_plast = sw_rd_pulse; end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] flat();
    logic [127:0] f;
    for (int k = 0; k < N_WR; k++) f[32*k +: 32] = mdl[k];
    return f;
  endfunction

  function automatic void exp_read(input logic [10:0] a, output logic [31:0] d, output logic [1:0] r);
    int idx;
    idx = int'(a >> 2);
    if (idx < N_WR) begin d = mdl[idx]; r = 2'b00; end
    else if (idx < N_WR + N_RD) begin d = sw_read32[32*(idx-N_WR) +: 32]; r = 2'b00; end
    else begin d = 32'h0; r = 2'b11; end
  endfunction

  // order: 0 = AW and W together, 1 = AW first by gap cycles, 2 = W first by gap cycles
  task automatic axi_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int order, input int gap, input int bhold);
    int c, p0, idx;
    bit aw_go, w_go, aw_sent, w_sent;
    logic [1:0] er;
    p0 = wr_pcnt;
    idx = int'(a >> 2);
    er = (idx < N_WR) ? 2'b00 : (idx < N_WR + N_RD) ? 2'b10 : 2'b11;
    awaddr = a; wdata = d; wstrb = s; bready = 1'b0;
    awvalid = (order != 2);
    wvalid  = (order != 1);
    aw_sent = 1'b0; w_sent = 1'b0; c = 0;
    while (!(aw_sent && w_sent) && c < 40) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(posedge clk); #1; c++;
      if (aw_go) begin awvalid = 1'b0; aw_sent = 1'b1; end
      if (w_go) begin wvalid = 1'b0; w_sent = 1'b1; end
      if (c == gap && order == 1 && !w_sent) wvalid = 1'b1;
      if (c == gap && order == 2 && !aw_sent) awvalid = 1'b1;
    end
    chk("w_handshake", 128'(aw_sent && w_sent), 128'(1));
    chk("b_latency", 128'(bvalid), 128'(1));
    for (int i = 0; i < bhold; i++) begin
      chk("b_backpressure", 128'({awready, wready, bvalid}), 128'(3'b001));
      @(posedge clk); #1;
    end
    chk("bresp", 128'(bresp), 128'(er));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("b_done", 128'(bvalid), 128'(0));
    if (idx < N_WR)
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    chk("ctl_regs", sw_write32, flat());
    chk("wr_pulse_cnt", 128'(wr_pcnt - p0), 128'((idx < N_WR) ? 1 : 0));
    if (idx < N_WR) chk("wr_pulse_bit", 128'(wr_plast), 128'(1 << idx));
  endtask

  task automatic axi_read(input logic [10:0] a, input int rhold, output logic [31:0] d);
    int c, p0, idx;
    logic [31:0] ed;
    logic [1:0] er;
    p0 = rd_pcnt;
    idx = int'(a >> 2);
    exp_read(a, ed, er);
    araddr = a; arvalid = 1'b1; rready = 1'b0; c = 0;
    while (!arready && c < 40) begin @(posedge clk); #1; c++; end
    chk("ar_ready", 128'(arready), 128'(1));
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("r_latency", 128'(rvalid), 128'(1));
    for (int i = 0; i < rhold; i++) begin
      chk("r_hold", 128'({arready, rvalid, rdata, rresp}), 128'({1'b0, 1'b1, ed, er}));
      @(posedge clk); #1;
    end
    d = rdata;
    chk("rdata", 128'(rdata), 128'(ed));
    chk("rresp", 128'(rresp), 128'(er));
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("r_done", 128'(rvalid), 128'(0));
    chk("rd_pulse_cnt", 128'(rd_pcnt - p0), 128'((idx >= N_WR && idx < N_WR + N_RD) ? 1 : 0));
    if (idx >= N_WR && idx < N_WR + N_RD) chk("rd_pulse_bit", 128'(rd_plast), 128'(1 << (idx - N_WR)));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rd2;
    int rp;
    for (int k = 0; k < N_WR; k++) mdl[k] = 32'h0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 128'({awready, wready, arready}), 128'(0));
    chk("rst_valid", 128'({bvalid, rvalid, bresp, rresp}), 128'(0));
    chk("rst_rdata", 128'(rdata), 128'(0));
    chk("rst_regs", sw_write32, 128'(0));
    chk("rst_pulses", 128'({sw_wr_pulse, sw_rd_pulse}), 128'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready_low", 128'({awready, wready, arready}), 128'(0));
    @(posedge clk); #1;
    chk("rst_release_ready_high", 128'({awready, wready, arready}), 128'(3'b111));

    // basic write and readback
    axi_write(11'h004, 32'hDEADBEEF, 4'b1111, 0, 0, 0);
    chk("reg1_deadbeef", 128'(sw_write32[63:32]), 128'(32'hDEADBEEF));
    axi_read(11'h004, 0, rd);

    // byte strobes
    axi_write(11'h000, 32'h11223344, 4'b1111, 0, 0, 0);
    axi_write(11'h000, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    chk("reg0_strobe", 128'(sw_write32[31:0]), 128'(32'h11BB33DD));
    axi_write(11'h000, 32'hFFFFFFFF, 4'b0000, 0, 0, 1);

    // AW before W and W before AW, with response back-pressure
    axi_write(11'h008, 32'h0BADF00D, 4'b1111, 1, 3, 5);
    axi_write(11'h00C, 32'hC001D00D, 4'b1111, 2, 3, 5);

    // status read and illegal write to status
    sw_read32[95:64] = 32'h0000CAFE;
    axi_read(11'h018, 2, rd);
    chk("status_cafe", 128'(rd), 128'(32'h0000CAFE));
    axi_write(11'h018, 32'h12345678, 4'b1111, 0, 0, 0);

    // unmapped region
    axi_read(11'h040, 0, rd);
    axi_write(11'h040, 32'h87654321, 4'b1111, 0, 0, 0);

    // same-edge read and write of one control register returns the old value
    rd2 = mdl[1];
    fork
      axi_write(11'h004, 32'h5A5A5A5A, 4'b1111, 0, 0, 0);
      axi_read(11'h004, 0, rd);
    join
    chk("same_edge_old_value", 128'(rd), 128'(rd2));

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      logic [8:0] idx;
      rp = int'($urandom_range(0, 2));
      idx = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(0, 11));
      axi_write({idx, 2'($urandom)}, $urandom, 4'($urandom), rp,
                (rp == 0) ? 0 : int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
      sw_read32 = {$urandom, $urandom, $urandom, $urandom};
      idx = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(0, 11));
      axi_read({idx, 2'($urandom)}, int'($urandom_range(0, 2)), rd);
    end

    // asynchronous reset while a write response is pending
    @(posedge clk); #1;
    awaddr = 11'h004; wdata = 32'h5; wstrb = 4'b1111; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pre_reset_bvalid", 128'(bvalid), 128'(1));
    chk("pre_reset_reg1", 128'(sw_write32[63:32]), 128'(32'h5));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_bvalid", 128'(bvalid), 128'(0));
    chk("async_reset_regs", sw_write32, 128'(0));
    chk("async_reset_ready", 128'({awready, wready, arready}), 128'(0));
    for (int k = 0; k < N_WR; k++) mdl[k] = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_write(11'h004, 32'h12345678, 4'b1111, 0, 0, 0);
    axi_read(11'h004, 0, rd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
